// File: rtl/axi_rd_arbiter.sv
// Two-port round-robin read arbiter in front of a single AXI4-style AR/R master.
// One transaction in flight; all outputs registered; watchdog aborts a stalled data phase.
module axi_rd_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    output logic          done0,
    output logic          done1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata,
    output logic          ARVALID,
    input  logic          ARREADY,
    output logic [AW-1:0] ARADDR,
    output logic [2:0]    ARPROT,
    input  logic          RVALID,
    output logic          RREADY,
    input  logic          RLAST,
    input  logic [DW-1:0] RDATA
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          arvalid_q, arvalid_d;
    logic [AW-1:0] araddr_q, araddr_d;
    logic [2:0]    arprot_q, arprot_d;
    logic          rready_q, rready_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [7:0]    wdog_q, wdog_d;
    // Port of the most recent grant; doubles as the owner of the transaction in flight.
    logic          last_grant_q, last_grant_d;
    logic          grant;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= StIdle;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arprot_q     <= 3'b000;
            rready_q     <= 1'b0;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            rdata_q      <= '0;
            wdog_q       <= 8'd0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arprot_q     <= arprot_d;
            rready_q     <= rready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            wdog_q       <= wdog_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arprot_d     = arprot_q;
        rready_d     = rready_q;
        done_d       = 2'b00;
        err_d        = 2'b00;
        rdata_d      = rdata_q;
        wdog_d       = wdog_q;
        last_grant_d = last_grant_q;
        grant        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // On a tie the port that did not win last time goes next.
                    grant        = (req0 && req1) ? ~last_grant_q : req1;
                    araddr_d     = grant ? addr1 : addr0;
                    arprot_d     = grant ? 3'b000 : 3'b100;
                    arvalid_d    = 1'b1;
                    last_grant_d = grant;
                    state_d      = StAddr;
                end
            end
            StAddr: begin
                if (arvalid_q && ARREADY) begin
                    arvalid_d = 1'b0;
                    araddr_d  = '0;
                    rready_d  = 1'b1;
                    wdog_d    = 8'd0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (RVALID) begin
                    rdata_d = RDATA;
                    if (RLAST) begin
                        rready_d = 1'b0;
                        done_d   = last_grant_q ? 2'b10 : 2'b01;
                        state_d  = StIdle;
                    end else begin
                        wdog_d = 8'd0;
                    end
                end else if (wdog_q == WdogLast) begin
                    rready_d = 1'b0;
                    err_d    = last_grant_q ? 2'b10 : 2'b01;
                    state_d  = StIdle;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign done0   = done_q[0];
    assign done1   = done_q[1];
    assign err0    = err_q[0];
    assign err1    = err_q[1];
    assign rdata   = rdata_q;
    assign ARVALID = arvalid_q;
    assign ARADDR  = araddr_q;
    assign ARPROT  = arprot_q;
    assign RREADY  = rready_q;

endmodule
